// File: rtl/btn_event_ctrl.sv
// Push-button event controller: synchronise, debounce on tick, detect press and
// hold-to-repeat per button, then serialise events onto one valid/ready stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | button released; a debounced high emits a press event
// ST_HOLD   | held after press; counting ticks toward the first repeat
// ST_REPEAT | auto-repeating; one repeat event every REPEAT_TICKS ticks
module btn_event_ctrl #(
  parameter int N            = 5,
  parameter int DEB_LEN      = 4,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 25,
  parameter int IDX_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [N-1:0]     btn_in,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_rep,
  output logic [N-1:0]     btn_level,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] REP_LAST  = (REPEAT_TICKS > 0) ? 16'(REPEAT_TICKS - 1) : 16'd0;
  localparam bit          REP_EN    = (REPEAT_TICKS > 0);

  logic [N-1:0]       sync_a;
  logic [N-1:0]       sync_b;
  logic [DEB_LEN-1:0] deb_sh [N];
  logic [DEB_LEN-1:0] deb_nx [N];

  state_t      state_q [N];
  state_t      state_d [N];
  logic [15:0] cnt_q   [N];
  logic [15:0] cnt_d   [N];
  logic [N-1:0] emit;
  logic [N-1:0] emit_rep;

  logic [N-1:0]     pend_q;
  logic [N-1:0]     prep_q;
  logic [N-1:0]     grant_oh;
  logic [N-1:0]     take;
  logic             grant_any;
  logic             grant_rep;
  logic [IDX_W-1:0] grant_idx;
  logic             load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      deb_nx[i] = {deb_sh[i][DEB_LEN-2:0], sync_b[i]};
    end
  end

  // Level changes only on a full run of equal samples; anything else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        deb_sh[i] <= '0;
      end
      btn_level <= '0;
    end else if (tick) begin
      for (int i = 0; i < N; i++) begin
        deb_sh[i] <= deb_nx[i];
        if (&deb_nx[i]) begin
          btn_level[i] <= 1'b1;
        end else if (~|deb_nx[i]) begin
          btn_level[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Release is checked first so it beats a same-cycle counter match.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      emit[i]     = 1'b0;
      emit_rep[i] = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (btn_level[i]) begin
            emit[i]    = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!btn_level[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else if (tick) begin
            if (cnt_q[i] == HOLD_LAST) begin
              if (REP_EN) begin
                emit[i]     = 1'b1;
                emit_rep[i] = 1'b1;
                cnt_d[i]    = '0;
                state_d[i]  = ST_REPEAT;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + 16'd1;
            end
          end
        end
        ST_REPEAT: begin
          if (!btn_level[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else if (tick) begin
            if (cnt_q[i] == REP_LAST) begin
              emit[i]     = 1'b1;
              emit_rep[i] = 1'b1;
              cnt_d[i]    = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 16'd1;
            end
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Lowest set pend bit wins; scanning downward leaves the lowest one last.
  always_comb begin
    grant_any = 1'b0;
    grant_rep = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_any   = 1'b1;
        grant_rep   = prep_q[i];
        grant_idx   = IDX_W'(i);
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign load = !evt_valid || evt_ready;
  assign take = load ? grant_oh : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      prep_q  <= '0;
      overrun <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (emit[i]) begin
          if (pend_q[i] && !take[i]) begin
            overrun <= 1'b1;
          end else begin
            pend_q[i] <= 1'b1;
            prep_q[i] <= emit_rep[i];
          end
        end else if (take[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_rep   <= 1'b0;
    end else if (load) begin
      if (grant_any) begin
        evt_valid <= 1'b1;
        evt_idx   <= grant_idx;
        evt_rep   <= grant_rep;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: one repeating instance and one with
// auto-repeat disabled, tick asserted every cycle.
module tb_btn_event_ctrl;

  localparam int N     = 5;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst;
  logic             tick;
  logic [N-1:0]     btn_in;
  logic             evt_ready;
  logic             evt_valid;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_rep;
  logic [N-1:0]     btn_level;
  logic             overrun;

  logic [N-1:0]     btn_nr;
  logic             ready_nr;
  logic             valid_nr;
  logic [IDX_W-1:0] idx_nr;
  logic             rep_nr;
  logic [N-1:0]     level_nr;
  logic             overrun_nr;

  btn_event_ctrl #(
    .N(N), .DEB_LEN(4), .HOLD_TICKS(10), .REPEAT_TICKS(3), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_in), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_idx(evt_idx), .evt_rep(evt_rep),
    .btn_level(btn_level), .overrun(overrun)
  );

  btn_event_ctrl #(
    .N(N), .DEB_LEN(4), .HOLD_TICKS(10), .REPEAT_TICKS(0), .IDX_W(IDX_W)
  ) dut_nr (
    .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_nr), .evt_ready(ready_nr),
    .evt_valid(valid_nr), .evt_idx(idx_nr), .evt_rep(rep_nr),
    .btn_level(level_nr), .overrun(overrun_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ev_idx[$];
  int ev_rep[$];
  int ev_cyc[$];
  int nr_idx[$];
  int nr_rep[$];
  int base;
  int base_nr;
  int rep_sum;
  int idx_sum;
  bit stable;
  bit glitch_seen;

  // Handshakes are logged with pre-edge values of the DUT outputs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && evt_valid && evt_ready) begin
      ev_idx.push_back(int'(evt_idx));
      ev_rep.push_back(int'(evt_rep));
      ev_cyc.push_back(cyc);
    end
    if (!rst && valid_nr && ready_nr) begin
      nr_idx.push_back(int'(idx_nr));
      nr_rep.push_back(int'(rep_nr));
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic track(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!(evt_valid === 1'b1 && evt_idx === 3'd3 && evt_rep === 1'b0)) stable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    tick      = 1'b1;
    btn_in    = '0;
    btn_nr    = '0;
    evt_ready = 1'b1;
    ready_nr  = 1'b1;

    wait_cyc(1);
    check_val("rst_valid", 32'(evt_valid), 0);
    check_val("rst_idx", 32'(evt_idx), 0);
    check_val("rst_rep", 32'(evt_rep), 0);
    check_val("rst_level", 32'(btn_level), 0);
    check_val("rst_overrun", 32'(overrun), 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);

    // Debounce and press latency on button 2
    base = ev_idx.size();
    btn_in[2] = 1'b1;
    wait_cyc(5);
    check_val("deb_lvl_pre", 32'(btn_level), 0);
    wait_cyc(1);
    check_val("deb_lvl_rise", 32'(btn_level), 32'b00100);
    btn_in[2] = 1'b0;
    wait_cyc(1);
    check_val("press_lat1", 32'(evt_valid), 0);
    wait_cyc(1);
    check_val("press_lat2", 32'(evt_valid), 1);
    check_val("press_idx_out", 32'(evt_idx), 2);
    check_val("press_rep_out", 32'(evt_rep), 0);
    wait_cyc(12);
    check_val("press_cnt", 32'(ev_idx.size() - base), 1);
    check_val("press_idx", 32'(qat(ev_idx, base)), 2);
    check_val("press_rep", 32'(qat(ev_rep, base)), 0);
    check_val("press_rel_lvl", 32'(btn_level), 0);

    // Three-tick glitch
    base = ev_idx.size();
    glitch_seen = 1'b0;
    btn_in[2] = 1'b1;
    wait_cyc(3);
    btn_in[2] = 1'b0;
    repeat (12) begin
      wait_cyc(1);
      if (btn_level != '0) glitch_seen = 1'b1;
    end
    check_val("glitch_lvl", 32'(glitch_seen), 0);
    check_val("glitch_cnt", 32'(ev_idx.size() - base), 0);

    // Auto-repeat on button 0, released on a repeat match tick
    base = ev_idx.size();
    btn_in[0] = 1'b1;
    wait_cyc(31);
    btn_in[0] = 1'b0;
    wait_cyc(15);
    rep_sum = 0;
    idx_sum = 0;
    for (int i = base; i < ev_idx.size(); i++) begin
      rep_sum += ev_rep[i];
      idx_sum += ev_idx[i];
    end
    check_val("rpt_cnt", 32'(ev_idx.size() - base), 8);
    check_val("rpt_first_rep", 32'(qat(ev_rep, base)), 0);
    check_val("rpt_repeats", 32'(rep_sum), 7);
    check_val("rpt_idx", 32'(idx_sum), 0);
    check_val("rpt_gap_hold", 32'(qat(ev_cyc, base + 1) - qat(ev_cyc, base)), 10);
    check_val("rpt_gap_1", 32'(qat(ev_cyc, base + 2) - qat(ev_cyc, base + 1)), 3);
    check_val("rpt_gap_last", 32'(qat(ev_cyc, base + 7) - qat(ev_cyc, base + 6)), 3);

    // Simultaneous press of buttons 4 and 1
    base = ev_idx.size();
    btn_in[4] = 1'b1;
    btn_in[1] = 1'b1;
    wait_cyc(6);
    check_val("simul_lvl", 32'(btn_level), 32'b10010);
    btn_in = '0;
    wait_cyc(12);
    check_val("simul_cnt", 32'(ev_idx.size() - base), 2);
    check_val("simul_first", 32'(qat(ev_idx, base)), 1);
    check_val("simul_second", 32'(qat(ev_idx, base + 1)), 4);
    check_val("simul_gap", 32'(qat(ev_cyc, base + 1) - qat(ev_cyc, base)), 1);

    // Backpressure and overrun on button 3
    evt_ready = 1'b0;
    base = ev_idx.size();
    btn_in[3] = 1'b1;
    wait_cyc(8);
    stable = (evt_valid === 1'b1 && evt_idx === 3'd3 && evt_rep === 1'b0);
    track(7);
    btn_in[3] = 1'b0;
    track(4);
    check_val("ovr_before", 32'(overrun), 0);
    track(1);
    check_val("ovr_set", 32'(overrun), 1);
    track(5);
    check_val("bp_stable", 32'(stable), 1);
    check_val("bp_no_xfer", 32'(ev_idx.size() - base), 0);
    evt_ready = 1'b1;
    wait_cyc(6);
    check_val("bp_cnt", 32'(ev_idx.size() - base), 2);
    check_val("bp_ev0_rep", 32'(qat(ev_rep, base)), 0);
    check_val("bp_ev1_rep", 32'(qat(ev_rep, base + 1)), 1);
    check_val("bp_ev1_idx", 32'(qat(ev_idx, base + 1)), 3);
    check_val("ovr_sticky", 32'(overrun), 1);
    check_val("bp_drained", 32'(evt_valid), 0);

    // Reset while button 1 is repeating with an event held on the output
    evt_ready = 1'b0;
    btn_in[1] = 1'b1;
    wait_cyc(20);
    check_val("pre_rst_valid", 32'(evt_valid), 1);
    check_val("pre_rst_idx", 32'(evt_idx), 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(evt_valid), 0);
    check_val("mid_rst_idx", 32'(evt_idx), 0);
    check_val("mid_rst_rep", 32'(evt_rep), 0);
    check_val("mid_rst_level", 32'(btn_level), 0);
    check_val("mid_rst_overrun", 32'(overrun), 0);
    btn_in = '0;
    wait_cyc(3);
    rst = 1'b0;
    evt_ready = 1'b1;
    base = ev_idx.size();
    wait_cyc(20);
    check_val("post_rst_cnt", 32'(ev_idx.size() - base), 0);
    check_val("post_rst_level", 32'(btn_level), 0);

    // Auto-repeat disabled: long hold gives one press, re-press gives another
    base_nr = nr_rep.size();
    btn_nr[0] = 1'b1;
    wait_cyc(500);
    check_val("norep_cnt", 32'(nr_rep.size() - base_nr), 1);
    check_val("norep_rep", 32'(qat(nr_rep, base_nr)), 0);
    check_val("norep_lvl", 32'(level_nr), 1);
    btn_nr[0] = 1'b0;
    wait_cyc(12);
    btn_nr[0] = 1'b1;
    wait_cyc(12);
    btn_nr[0] = 1'b0;
    wait_cyc(12);
    check_val("norep_cnt2", 32'(nr_rep.size() - base_nr), 2);
    check_val("norep_rep2", 32'(qat(nr_rep, base_nr + 1)), 0);
    check_val("norep_idx2", 32'(qat(nr_idx, base_nr + 1)), 0);
    check_val("norep_overrun", 32'(overrun_nr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
Input-event controller for the board's push-buttons. It sequences synchronisation, tick-paced debouncing, press detection and hold-to-auto-repeat for N buttons. It then arbitrates the resulting per-button events onto a single valid/ready event stream. The stream feeds the editor/menu logic in place of ad-hoc per-button debounce and one-pulse chains.

Parameters:
N, 5, number of buttons (1..16)
DEB_LEN, 4, consecutive equal tick-samples required to change a debounced level (2..8)
HOLD_TICKS, 100, ticks a button must be held after the press event before the first repeat event (>=1)
REPEAT_TICKS, 25, ticks between repeat events while held; 0 disables auto-repeat
IDX_W, 3, width of evt_idx; must be >= clog2(N)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset, all state cleared
tick  in  1  one-cycle sample enable (e.g. ~400 Hz strobe derived in the clk domain)
btn_in  in  N  raw asynchronous button inputs
evt_ready  in  1  consumer accepts the event this cycle
evt_valid  out  1  event present on evt_idx/evt_rep
evt_idx  out  IDX_W  index of the button that produced the event
evt_rep  out  1  0 = initial press, 1 = auto-repeat
btn_level  out  N  debounced button levels
overrun  out  1  sticky: an event was dropped because one was already pending for that button

Behaviour:
- Reset (async, rst=1): all synchronisers, shift registers, counters and pending bits are 0. Every FSM is IDLE. evt_valid, evt_idx, evt_rep, btn_level and overrun are 0. Deasserting rst mid-hold restarts from IDLE; no event is emitted for a button already low.
- Sync: two-flop synchroniser per bit, clocked every clk cycle.
- Debounce: only on cycles with tick=1, shift the synced bit into a DEB_LEN-bit register.
  - btn_level[i] goes to 1 when the register is all-ones and to 0 when it is all-zeros.
  - Otherwise btn_level[i] holds (hysteresis).
  - btn_level[i] updates the cycle after the qualifying tick.
- Per-button FSM (IDLE, HOLD, REPEAT), with a 16-bit tick counter cnt:
  - IDLE: btn_level rise -> emit press event (rep=0), cnt=0, go to HOLD.
  - HOLD: on tick, cnt++. When cnt==HOLD_TICKS-1 on a tick -> emit repeat, cnt=0, go to REPEAT. If REPEAT_TICKS=0, emit nothing and stay in HOLD with cnt saturated.
  - REPEAT: on tick, cnt++. When cnt==REPEAT_TICKS-1 on a tick -> emit repeat, cnt=0.
  - HOLD or REPEAT: btn_level low -> IDLE, cnt=0. Release has priority over a simultaneous counter match: no event is emitted.
- Pending stage: an emitted event sets pend[i] and stores rep[i] in the same cycle as the FSM decision.
  - If pend[i] is already set and is not being transferred this cycle: the new event is dropped, pend[i] and rep[i] are unchanged, and overrun is set to 1. overrun is cleared only by rst.
  - If pend[i] is transferred in the same cycle a new event arrives: the new event is loaded into pend[i].
- Output register and arbitration:
  - When evt_valid=0, or when evt_valid=1 and evt_ready=1, the output loads the lowest-index set pend bit and clears that bit. The loaded event appears on the outputs the next cycle.
  - If no pend bit is set, evt_valid drops to 0.
  - While evt_valid=1 and evt_ready=0, evt_idx and evt_rep hold stable and no pend bit is cleared.
  - Throughput: one event per cycle.
  - Latency from btn_level rise to evt_valid is 2 cycles (pend is set 1 cycle after the rise, evt_valid 1 cycle after that) with an empty output.
- Fairness: fixed priority, lower index wins. Starvation is acceptable because events are tick-paced.

Test Plan:
- Reset mid-operation: assert rst while button 1 is in REPEAT with evt_valid=1 -> all outputs are 0 immediately; after release of rst with the button low, no event is emitted.
- Debounce/press: tick every cycle, DEB_LEN=4, btn_in[2] held high -> btn_level[2] rises once 4 synced samples are 1. Exactly one event {idx=2, rep=0} with evt_ready=1. A 3-tick glitch produces no event and btn_level stays 0.
- Auto-repeat: HOLD_TICKS=10, REPEAT_TICKS=3, button 0 held 30 ticks -> press event, first repeat 10 ticks after the press, then repeats every 3 ticks, 7 repeats total. Releasing on a match tick gives no event for that tick.
- Simultaneous press: buttons 4 and 1 debounce on the same tick, evt_ready=1 -> event idx=1 then idx=4 on consecutive cycles.
- Backpressure and overrun: evt_ready=0 while button 3 produces a press and then 2 repeats -> evt_valid stays 1 with idx=3, rep=0 stable. One repeat is pending, the second is dropped, and overrun=1. Raising evt_ready delivers exactly 2 events.
- REPEAT_TICKS=0: button held 500 ticks -> exactly one press event; release and re-press -> a second press event.
